vga_rgb_controller_param: RTL
=============================

Name: vga_rgb_controller_param

Overview:
Parameterised successor to the fixed 640x480 VGA RGB controller. Contains its own pixel-tick divider and h/v timing counters, plus a four-mode pattern generator: switch colour, 8-bar colour bar, checkerboard and grey gradient. Mode changes take effect only at frame boundaries. Outputs go through a 2-tick register pipeline so that syncs, DE, coordinates and colour leave the block aligned. Sits directly under the board top, driving the VGA connector.

Parameters:
COLOR_W, 4, bits per colour channel
PIX_DIV, 4, system clocks per pixel tick (≥1)
H_ACTIVE, 640, visible pixels per line (multiple of 8)
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
r_sw  in  COLOR_W  switch red level
g_sw  in  COLOR_W  switch green level
b_sw  in  COLOR_W  switch blue level
mode_sel  in  2  requested mode: 0 switch, 1 bars, 2 checker, 3 gradient
h_sync  out  1  horizontal sync, polarity per SYNC_POL
v_sync  out  1  vertical sync, polarity per SYNC_POL
DE  out  1  display enable, aligned with colour
r_port  out  COLOR_W  red output
g_port  out  COLOR_W  green output
b_port  out  COLOR_W  blue output
pixel_x  out  10  x coordinate aligned with colour
pixel_y  out  10  y coordinate aligned with colour
frame_start  out  1  one-clk pulse on frame wrap
mode_active  out  2  mode currently in force
frame_count  out  16  frames since reset, wraps at 2^16

Behaviour:
- Reset state: all counters 0; DE, colour, pixel_x/y, frame_start, mode_active and frame_count are 0; h_sync/v_sync at the inactive level (1 if SYNC_POL=0).
- Tick: divider counts 0..PIX_DIV-1. tick=1 for one clk when the divider is at PIX_DIV-1. With PIX_DIV=1, tick is always 1.
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise for the vertical parameters.
- Counters: h_cnt advances on tick and wraps H_TOTAL-1→0. v_cnt advances when h_cnt wraps and wraps V_TOTAL-1→0.
- Stage 1 (on tick), from (h_cnt, v_cnt):
  - de = h<H_ACTIVE && v<V_ACTIVE
  - hs active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC; vs uses the same form on v
  - compute pattern colour from mode_active
- Stage 2 (on tick): register all Stage 1 results to the ports.
  - Every port changes only on a tick clk.
  - Latency is 2 ticks from counter to port; all port fields are mutually aligned.
- Blanking: colour is forced to 0 whenever DE=0, in every mode.
- Patterns (x,y = counter values, MAX = 2^COLOR_W-1):
  - Mode 0: {r_sw, g_sw, b_sw}, passed through the pipeline.
  - Mode 1: bar = x/(H_ACTIVE/8). Order: white, yellow, cyan, green, magenta, red, blue, black. Each channel is MAX or 0.
  - Mode 2: if x[CHECK_LOG2]^y[CHECK_LOG2] the output is the switch colour, else 0.
  - Mode 3: g = (x·2^COLOR_W)/H_ACTIVE, clamped to MAX. r = g = b.
- Frame wrap: the tick where (h,v) goes (H_TOTAL-1, V_TOTAL-1)→(0,0).
  - On that tick, mode_active ← mode_sel, frame_count increments, and frame_start=1 for that clk only.
  - mode_sel changes mid-frame are ignored.
  - The first frame after reset uses mode 0.
- Reset mid-frame: everything returns to the reset state asynchronously. Timing restarts at (0,0) on release. frame_count returns to 0.
- Inputs are treated as quasi-static. No synchroniser is required inside the block; r_sw/g_sw/b_sw are sampled every tick.

Test Plan:
- Defaults, 2 frames → h_sync low for exactly 384 clks per line; line period 3200 clks; v_sync low for 2 lines (6400 clks); frame = 525 lines; DE high for 640 ticks per line on lines 0..479 only.
- Mode 0, sw=A/5/3 → RGB=A,5,3 whenever DE=1 and 0,0,0 during blanking. pixel_x=0 appears on the same tick as the first DE=1.
- Mode 1 requested, after a frame wrap → x=0 gives F,F,F; x=80 gives F,F,0; x=400 gives F,0,0; x=639 gives 0,0,0.
- Toggle mode_sel 0→2 at line 100 → output stays mode 0 until frame_start, then checker: (0,0) gives black; (32,0) gives the switch colour. mode_active=2 and frame_count=2.
- Small config (H_ACTIVE=8, all porches 1, V_ACTIVE=4, PIX_DIV=1, SYNC_POL=1), mode 3, COLOR_W=4 → greys 0,2,4,…,14 across a line; syncs active-high.
- Assert reset at line 200 → ports go to reset values within the same clk. After release, the first DE rises exactly 2 ticks after the counters start.

Source files
------------

// File: rtl/vga_rgb_controller_param_if.sv
// Signal bundle between the VGA RGB controller and its board-level user.
// slave is the controller's view; master is the driver/observer's view.
interface vga_rgb_controller_param_if #(
   parameter int COLOR_W = 4
);
   logic [COLOR_W-1:0] r_sw;
   logic [COLOR_W-1:0] g_sw;
   logic [COLOR_W-1:0] b_sw;
   logic [1:0]         mode_sel;
   logic               h_sync;
   logic               v_sync;
   logic               DE;
   logic [COLOR_W-1:0] r_port;
   logic [COLOR_W-1:0] g_port;
   logic [COLOR_W-1:0] b_port;
   logic [9:0]         pixel_x;
   logic [9:0]         pixel_y;
   logic               frame_start;
   logic [1:0]         mode_active;
   logic [15:0]        frame_count;

   modport slave (
      input  r_sw, g_sw, b_sw, mode_sel,
      output h_sync, v_sync, DE, r_port, g_port, b_port,
      output pixel_x, pixel_y, frame_start, mode_active, frame_count
   );

   modport master (
      output r_sw, g_sw, b_sw, mode_sel,
      input  h_sync, v_sync, DE, r_port, g_port, b_port,
      input  pixel_x, pixel_y, frame_start, mode_active, frame_count
   );
endinterface

// File: rtl/vga_rgb_controller_param.sv
// Parameterised VGA timing generator with a four-mode pattern source and a
// two-tick output pipeline keeping syncs, DE, coordinates and colour aligned.
module vga_rgb_controller_param #(
   parameter int COLOR_W    = 4,
   parameter int PIX_DIV    = 4,
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter int SYNC_POL   = 0,
   parameter int CHECK_LOG2 = 5
) (
   input logic                      clk,
   input logic                      reset,
   vga_rgb_controller_param_if.slave vga
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int unsigned MAX_I = (2 ** COLOR_W) - 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic          SYNC_IDLE = (SYNC_POL == 0);

   logic [DW-1:0]      div_cnt;
   logic               tick;
   logic [HW-1:0]      h_cnt;
   logic [VW-1:0]      v_cnt;
   logic               h_last, v_last, frame_wrap;
   logic [1:0]         mode_q;
   logic [15:0]        frame_cnt;
   logic               fs_q;

   logic               de, hs_act, vs_act;
   logic [COLOR_W-1:0] pat_r, pat_g, pat_b;
   logic [31:0]        x32, y32, grey32, chk;
   logic [2:0]         bar;
   logic [COLOR_W-1:0] grey;

   logic               s1_de, s1_hs, s1_vs;
   logic [9:0]         s1_x, s1_y;
   logic [COLOR_W-1:0] s1_r, s1_g, s1_b;
   logic               s2_de, s2_hs, s2_vs;
   logic [9:0]         s2_x, s2_y;
   logic [COLOR_W-1:0] s2_r, s2_g, s2_b;

   assign tick       = (div_cnt == DIV_LAST);
   assign h_last     = (h_cnt == H_LAST);
   assign v_last     = (v_cnt == V_LAST);
   assign frame_wrap = tick && h_last && v_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // The requested mode is only adopted on the frame-wrap tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode_q    <= '0;
         frame_cnt <= '0;
         fs_q      <= 1'b0;
      end else begin
         fs_q <= frame_wrap;
         if (frame_wrap) begin
            mode_q    <= vga.mode_sel;
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      de     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
      vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
      x32    = 32'(h_cnt);
      y32    = 32'(v_cnt);
      bar    = 3'(x32 / BAR_W);
      grey32 = (x32 << COLOR_W) / H_ACTIVE;
      grey   = (grey32 > MAX_I) ? '1 : grey32[COLOR_W-1:0];
      chk    = ((x32 ^ y32) >> CHECK_LOG2) & 32'd1;
      pat_r  = '0;
      pat_g  = '0;
      pat_b  = '0;
      case (mode_q)
         2'd0: begin
            pat_r = vga.r_sw;
            pat_g = vga.g_sw;
            pat_b = vga.b_sw;
         end
         // Bar order white..black maps onto inverted bits of the bar index.
         2'd1: begin
            pat_r = {COLOR_W{~bar[1]}};
            pat_g = {COLOR_W{~bar[2]}};
            pat_b = {COLOR_W{~bar[0]}};
         end
         2'd2: begin
            if (chk != 32'd0) begin
               pat_r = vga.r_sw;
               pat_g = vga.g_sw;
               pat_b = vga.b_sw;
            end
         end
         default: begin
            pat_r = grey;
            pat_g = grey;
            pat_b = grey;
         end
      endcase
      if (!de) begin
         pat_r = '0;
         pat_g = '0;
         pat_b = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_de <= 1'b0;     s2_de <= 1'b0;
         s1_hs <= SYNC_IDLE; s2_hs <= SYNC_IDLE;
         s1_vs <= SYNC_IDLE; s2_vs <= SYNC_IDLE;
         s1_x  <= '0;       s2_x  <= '0;
         s1_y  <= '0;       s2_y  <= '0;
         s1_r  <= '0;       s2_r  <= '0;
         s1_g  <= '0;       s2_g  <= '0;
         s1_b  <= '0;       s2_b  <= '0;
      end else if (tick) begin
         s1_de <= de;
         s1_hs <= hs_act ^ SYNC_IDLE;
         s1_vs <= vs_act ^ SYNC_IDLE;
         s1_x  <= 10'(h_cnt);
         s1_y  <= 10'(v_cnt);
         s1_r  <= pat_r;
         s1_g  <= pat_g;
         s1_b  <= pat_b;
         s2_de <= s1_de;
         s2_hs <= s1_hs;
         s2_vs <= s1_vs;
         s2_x  <= s1_x;
         s2_y  <= s1_y;
         s2_r  <= s1_r;
         s2_g  <= s1_g;
         s2_b  <= s1_b;
      end
   end

   assign vga.h_sync      = s2_hs;
   assign vga.v_sync      = s2_vs;
   assign vga.DE          = s2_de;
   assign vga.pixel_x     = s2_x;
   assign vga.pixel_y     = s2_y;
   assign vga.r_port      = s2_r;
   assign vga.g_port      = s2_g;
   assign vga.b_port      = s2_b;
   assign vga.frame_start = fs_q;
   assign vga.mode_active = mode_q;
   assign vga.frame_count = frame_cnt;
endmodule
